pdecoder_24: RTL
================

Name: pdecoder_24

Overview:
- Sequenced 2-to-4 decoder: the companion of the team's 4:2 priority encoder, rebuilding one-hot request lines from a 2-bit encoded index.
- Accepts a 2-bit code over a valid/ready handshake and drives the matching one-hot line for a fixed number of cycles.
- An optional inter-pulse gap follows each pulse.
- Sits downstream of the encoder or a code FIFO, driving strobe/select lines.

Parameters:
HOLD, 4, cycles each decoded line stays asserted (legal range >= 1)
GAP, 1, idle cycles forced after each pulse before the next output (legal range >= 0)
CW, 8, width of the optional accept counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
i  input  2  encoded index to decode
i_valid  input  1  code on i is valid
i_ready  output  1  block can accept a code this cycle
en  input  1  acceptance enable; 0 blocks new accepts only
y  output  4  one-hot decoded output, registered
y_valid  output  1  y carries a live pulse
busy  output  1  state is not IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, y=4'b0000, y_valid=0, busy=0, counter=0, latched code=0. Outputs clear immediately, not at the next edge.
- i_ready is combinational:
  - i_ready = en & (state==IDLE | (state==DRIVE & cnt==0 & GAP==0)).
  - It never depends on i_valid.
- Accept: i_valid & i_ready sampled at a rising edge.
- States:
  - IDLE
    - On accept: y<=1<<i, y_valid<=1, cnt<=HOLD-1, go DRIVE.
    - Otherwise hold y=0.
  - DRIVE
    - If cnt!=0: cnt<=cnt-1 and y holds.
    - If cnt==0 and accept (GAP=0 only): y<=1<<i, cnt<=HOLD-1, stay DRIVE. This gives back-to-back pulses with no zero cycle between them.
    - If cnt==0, no accept, GAP>0: y<=0, y_valid<=0, cnt<=GAP-1, go GAP.
    - If cnt==0, no accept, GAP==0: y<=0, y_valid<=0, go IDLE.
  - GAP
    - y=0.
    - If cnt!=0: cnt<=cnt-1.
    - If cnt==0: go IDLE.
- Latency: y reflects an accepted code from the edge of acceptance, so it is visible in the cycle after the handshake. It stays for exactly HOLD cycles.
- Minimum spacing between accepts: HOLD+GAP+1 cycles when GAP>0; HOLD cycles when GAP=0.
- Invariant: y is 0 or exactly one-hot; y_valid == (y != 0).
- en deassert mid-pulse: the current pulse and gap complete normally; only new accepts are blocked. An en toggle never truncates a pulse.
- i_valid held high while i_ready=0: no effect; the code is ignored until i_ready=1 (no internal buffering).
- i changes while y is live: no effect; the code is latched at accept.
- i containing X/Z with i_valid=1 is a stimulus error; the bench never drives it.
- busy = (state != IDLE).
- Counter width: ceil(log2(max(HOLD, GAP, 2))) bits.

Optional Feature:
- Macro: PDECODER_ACCEPT_CNT_EN.
- Defined:
  - Adds output port acc_cnt [CW-1:0].
  - acc_cnt increments by 1 on every accept and wraps from 2^CW-1 to 0.
  - Reset value is 0 (async, with rst).
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset/basic decode (HOLD=4, GAP=1): rst pulse mid-run -> y=0000, y_valid=0 immediately. Then i=2'b10 with i_valid for 1 cycle -> y=0100 for exactly 4 cycles, 1 gap cycle, i_ready returns high on cycle 6.
- All codes: i=0,1,2,3 in sequence -> y=0001, 0010, 0100, 1000 respectively. y is never multi-hot; y_valid matches y!=0 every cycle.
- Back-to-back (GAP=0, HOLD=2): i_valid held high, i=3 then i=1 -> y=1000,1000,0010,0010 with no zero cycle between pulses.
- en gating: en=0 during DRIVE with i_valid=1 -> pulse finishes its HOLD cycles, no new accept. Re-raise en -> accept on the next i_ready cycle.
- Reset mid-pulse: rst asserted on the 2nd DRIVE cycle -> y=0000 and busy=0 asynchronously. After release, a new code decodes normally.
- PDECODER_ACCEPT_CNT_EN, CW=2: 5 accepts -> acc_cnt reads 1,2,3,0,1. Build without the macro -> compiles with no acc_cnt port.

Source files
------------

// File: rtl/pdecoder_24.sv
// Sequenced 2-to-4 decoder: accepts a 2-bit code via valid/ready, drives the one-hot line for HOLD cycles, then GAP idle cycles.
// Latency: y is registered and appears in the cycle after the accept. i_ready is low while a pulse or gap is in progress.
// Optional accept counter output acc_cnt is present only when PDECODER_ACCEPT_CNT_EN is defined.
module pdecoder_24 #(
   parameter int HOLD = 4,
   parameter int GAP  = 1,
   parameter int CW   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    i,
   input  logic          i_valid,
   output logic          i_ready,
   input  logic          en,
   output logic [3:0]    y,
   output logic          y_valid,
   output logic          busy
`ifdef PDECODER_ACCEPT_CNT_EN
   ,
   output logic [CW-1:0] acc_cnt
`endif
);

   localparam int MXV  = (HOLD > GAP) ? ((HOLD > 2) ? HOLD : 2) : ((GAP > 2) ? GAP : 2);
   localparam int CNTW = $clog2(MXV);
   localparam logic [CNTW-1:0] HOLD_M1 = CNTW'(HOLD - 1);
   localparam logic [CNTW-1:0] GAP_M1  = (GAP > 0) ? CNTW'(GAP - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

   state_t            state;
   logic [CNTW-1:0]   cnt;
   logic              accept;

   // With GAP==0 the last DRIVE cycle may take the next code so pulses abut.
   assign i_ready = en & ((state == S_IDLE) |
                          ((state == S_DRIVE) & (cnt == '0) & (GAP == 0)));
   assign accept  = i_valid & i_ready;
   assign busy    = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         y       <= 4'b0000;
         y_valid <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  y       <= 4'b0001 << i;
                  y_valid <= 1'b1;
                  cnt     <= HOLD_M1;
                  state   <= S_DRIVE;
               end else begin
                  y       <= 4'b0000;
                  y_valid <= 1'b0;
               end
            end
            S_DRIVE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (accept) begin
                  y       <= 4'b0001 << i;
                  y_valid <= 1'b1;
                  cnt     <= HOLD_M1;
               end else if (GAP > 0) begin
                  y       <= 4'b0000;
                  y_valid <= 1'b0;
                  cnt     <= GAP_M1;
                  state   <= S_GAP;
               end else begin
                  y       <= 4'b0000;
                  y_valid <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            S_GAP: begin
               y       <= 4'b0000;
               y_valid <= 1'b0;
               if (cnt != '0) cnt <= cnt - 1'b1;
               else           state <= S_IDLE;
            end
            default: begin
               state   <= S_IDLE;
               y       <= 4'b0000;
               y_valid <= 1'b0;
               cnt     <= '0;
            end
         endcase
      end
   end

`ifdef PDECODER_ACCEPT_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         acc_cnt <= '0;
      else if (accept) acc_cnt <= acc_cnt + 1'b1;
   end
`endif

endmodule
